// File: rtl/serial_deframer.sv
// serial_deframer: recovers start/data/parity/stop framed words from a 1-bit
// serial stream, hands good words to a single-entry valid/ready output register
// and counts link errors in a saturating counter.
module serial_deframer #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Even parity: the parity bit equals the XOR of all data bits.
    function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_parity_ok;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_out_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overflow;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_parity_ok;
    logic                   w_cnt_clr;
    logic                   w_shift_en;
    logic                   w_parity_ld;
    logic                   w_deliver;
    logic                   w_perr_det;
    logic                   w_ferr_det;
    logic                   w_ovf_det;
    logic                   w_err_evt;

    // Without a parity bit every frame counts as parity-clean.
    assign w_parity_ok = (PARITY_EN != 0) ? r_parity_ok : 1'b1;
    assign w_err_evt   = w_perr_det | w_ferr_det | w_ovf_det;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; STOP always returns to IDLE so it never samples a start bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == LAST_BIT) begin
                    if (PARITY_EN != 0) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes and frame verdict (bad stop beats bad parity).
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_parity_ld = 1'b0;
        w_deliver   = 1'b0;
        w_perr_det  = 1'b0;
        w_ferr_det  = 1'b0;
        w_ovf_det   = 1'b0;
        case (r_state)
            S_IDLE:   w_cnt_clr   = 1'b1;
            S_DATA:   w_shift_en  = 1'b1;
            S_PARITY: w_parity_ld = 1'b1;
            S_STOP: begin
                if (in) begin
                    w_ferr_det = 1'b1;
                end else if (!w_parity_ok) begin
                    w_perr_det = 1'b1;
                end else if (r_out_valid && !out_ready) begin
                    w_ovf_det = 1'b1;
                end else begin
                    w_deliver = 1'b1;
                end
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    // Receive datapath: bit counter, MSB-first shift register, parity verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_shift     <= {DATA_W{1'b0}};
            r_parity_ok <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= {CNT_W{1'b0}};
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_shift[DATA_W-2:0], in};
            end
            if (w_parity_ld) begin
                r_parity_ok <= (in == f_even_parity(r_shift));
            end
        end
    end

    // Single-entry output register; a delivery may coincide with an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
        end else if (w_deliver) begin
            r_out_data  <= r_shift;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Registered one-cycle error pulses and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_err_cnt    <= {ERR_CNT_W{1'b0}};
        end else begin
            r_parity_err <= w_perr_det;
            r_frame_err  <= w_ferr_det;
            r_overflow   <= w_ovf_det;
            if (w_err_evt && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer (DATA_W=8, PARITY_EN=1, ERR_CNT_W=8).
module tb_serial_deframer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [7:0] err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    serial_deframer #(.DATA_W(8), .PARITY_EN(1), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (ser_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one serial bit, wait for the edge, sample 1 time unit later.
    task automatic tick(input logic b);
        ser_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset  = 1'b0;
    endtask

    // Start bit, 8 data bits MSB-first, parity bit (stop bit sent by caller).
    task automatic send_body(input logic [7:0] d, input logic p);
        tick(1'b1);
        for (int i = 7; i >= 0; i--) begin
            tick(d[i]);
        end
        tick(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_body(d, p);
        tick(s);
    endtask

    initial begin
        logic seen_activity;

        //                data   p     stop  exp_d  v     perr  ferr  cnt
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{8'h80, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd3};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[6] = '{8'h7E, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[7] = '{8'hC3, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0, 8'd4};

        ser_in    = 1'b0;
        out_ready = 1'b1;

        // Reset and idle line.
        do_reset();
        check("rst_data", out_data, 8'h00);
        check("rst_cnt", err_cnt, 8'h00);
        seen_activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (out_valid || parity_err || frame_err || overflow) begin
                seen_activity = 1'b1;
            end
        end
        check("idle_activity", seen_activity, 1'b0);
        check("idle_cnt", err_cnt, 8'h00);

        // Frame table, consumer always ready.
        for (int v = 0; v < 8; v++) begin
            send_body(vecs[v].data, vecs[v].pbit);
            check("pre_stop_valid", out_valid, 1'b0);
            tick(vecs[v].stop);
            check("stop_data", out_data, vecs[v].exp_data);
            check("stop_valid", out_valid, vecs[v].exp_valid);
            check("stop_perr", parity_err, vecs[v].exp_perr);
            check("stop_ferr", frame_err, vecs[v].exp_ferr);
            check("stop_ovf", overflow, 1'b0);
            check("stop_cnt", err_cnt, vecs[v].exp_cnt);
            tick(1'b0);
            check("after_valid", out_valid, 1'b0);
            check("after_pulses", {parity_err, frame_err, overflow}, 3'b000);
            check("after_data", out_data, vecs[v].exp_data);
        end

        // Overflow: consumer stalled, two frames back-to-back.
        do_reset();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        check("ovf_first_valid", out_valid, 1'b1);
        check("ovf_first_data", out_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b0);
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_data_held", out_data, 8'h11);
        check("ovf_valid_held", out_valid, 1'b1);
        check("ovf_cnt", err_cnt, 8'd1);
        tick(1'b0);
        check("ovf_pulse_end", overflow, 1'b0);
        check("ovf_data_stable", out_data, 8'h11);
        out_ready = 1'b1;
        tick(1'b0);
        check("ovf_accept_valid", out_valid, 1'b0);
        check("ovf_accept_data", out_data, 8'h11);

        // Delivery on the same edge as an accept replaces the word, no overflow.
        out_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0);
        check("sim_first", out_data, 8'h33);
        send_body(8'h44, 1'b0);
        out_ready = 1'b1;
        tick(1'b0);
        check("sim_data", out_data, 8'h44);
        check("sim_valid", out_valid, 1'b1);
        check("sim_ovf", overflow, 1'b0);
        check("sim_cnt", err_cnt, 8'd1);
        tick(1'b0);
        check("sim_accept", out_valid, 1'b0);

        // Reset in the middle of a frame discards it.
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        tick(1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("mid_rst_new_data", out_data, 8'hC3);
        check("mid_rst_new_valid", out_valid, 1'b1);
        check("mid_rst_cnt", err_cnt, 8'd0);

        // Saturation of the error counter.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send_frame(8'h5A, 1'b0, 1'b1);
        end
        check("sat_255", err_cnt, 8'hFF);
        for (int i = 0; i < 45; i++) begin
            send_frame(8'h5A, 1'b0, 1'b1);
        end
        check("sat_300", err_cnt, 8'hFF);
        check("sat_ferr_pulse", frame_err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
